// File: rtl/boot_mem_responder_pkg.sv
// Shared definitions for the boot memory responder: boot FSM state encoding
// and the RISC-V canonical NOP returned whenever the fetch port has nothing valid.
package boot_mem_responder_pkg;

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } boot_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/boot_mem_responder_boot_loader_fsm.sv
// Boot stream loader: accepts a little-endian 16-bit word count followed by
// little-endian 32-bit instruction words, emits IM write strobes and holds the
// core in reset until the program is loaded.
module boot_loader_fsm
    import boot_mem_responder_pkg::*;
#(
    parameter int IM_WORDS = 1024,
    parameter int IM_AW    = $clog2(IM_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       boot_data,
    input  logic             boot_valid,
    output logic             boot_ready,
    output logic             boot_err,
    output logic             core_rst_n,
    output logic             run,
    output logic             im_we,
    output logic [IM_AW-1:0] im_waddr,
    output logic [31:0]      im_wdata
);

    // Word count is compared one bit wider so an IM_WORDS of 65536 still works.
    localparam logic [16:0] IM_LIMIT = 17'(IM_WORDS);

    boot_state_t state;
    logic [15:0] cnt;
    logic [1:0]  byte_idx;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [23:0] asm_bytes;
    logic        hs;
    logic [15:0] len_n;
    logic [15:0] cnt_inc;

    assign hs      = boot_valid & boot_ready;
    assign len_n   = {boot_data, len_lo};
    assign cnt_inc = cnt + 16'd1;

    assign run      = (state == ST_RUN);
    assign im_we    = (state == ST_DATA) && hs && (byte_idx == 2'd3);
    assign im_waddr = cnt[IM_AW-1:0];
    assign im_wdata = {boot_data, asm_bytes};

    // Boot FSM: handshake, word counting and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LEN0;
            cnt        <= '0;
            byte_idx   <= '0;
            boot_ready <= 1'b0;
            boot_err   <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            // Core leaves reset one edge after RUN is reached.
            core_rst_n <= (state == ST_RUN);
            boot_ready <= 1'b1;
            case (state)
                ST_LEN0: begin
                    if (hs) state <= ST_LEN1;
                end
                ST_LEN1: begin
                    if (hs) begin
                        cnt      <= '0;
                        byte_idx <= '0;
                        if (len_n == 16'd0) begin
                            state      <= ST_RUN;
                            boot_ready <= 1'b0;
                        end else if ({1'b0, len_n} > IM_LIMIT) begin
                            state      <= ST_ERR;
                            boot_ready <= 1'b0;
                            boot_err   <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == len) begin
                                state      <= ST_RUN;
                                boot_ready <= 1'b0;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    boot_ready <= 1'b0;
                end
                ST_ERR: begin
                    boot_ready <= 1'b0;
                    boot_err   <= 1'b1;
                end
                default: begin
                    state      <= ST_ERR;
                    boot_ready <= 1'b0;
                    boot_err   <= 1'b1;
                end
            endcase
        end
    end

    // Length and partial-word capture; pure data, so no reset.
    always_ff @(posedge clk) begin
        if (hs && state == ST_LEN0) len_lo <= boot_data;
        if (hs && state == ST_LEN1) len    <= len_n;
        if (hs && state == ST_DATA) asm_bytes <= {boot_data, asm_bytes[23:8]};
    end

endmodule

// File: rtl/boot_mem_responder.sv
// Memory-side responder for the RV64IF core: instruction and data memories with
// combinational reads, plus the boot loader that fills IM and releases core reset.
module boot_mem_responder
    import boot_mem_responder_pkg::*;
#(
    parameter int IM_WORDS = 1024,
    parameter int DM_WORDS = 1024
) (
    input  logic        in_Clk,
    input  logic        in_Rst,
    input  logic [7:0]  in_boot_data,
    input  logic        in_boot_valid,
    output logic        out_boot_ready,
    output logic        out_boot_err,
    output logic        out_core_Rst_N,
    input  logic [63:0] in_inst_addr,
    output logic [31:0] out_inst,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wr_data,
    input  logic        in_DM_wr_en,
    output logic [63:0] out_DM_data,
    output logic        out_fault
);

    localparam int IM_AW = $clog2(IM_WORDS);
    localparam int DM_AW = $clog2(DM_WORDS);

    logic [31:0] im [IM_WORDS];
    logic [63:0] dm [DM_WORDS];

    logic             run;
    logic             im_we;
    logic [IM_AW-1:0] im_waddr;
    logic [31:0]      im_wdata;

    logic [IM_AW-1:0] inst_idx;
    logic [DM_AW-1:0] dm_idx;
    logic             inst_oor;
    logic             dm_oor;
    logic             unused_addr_bits;

    boot_loader_fsm #(
        .IM_WORDS (IM_WORDS),
        .IM_AW    (IM_AW)
    ) u_boot_loader_fsm (
        .clk        (in_Clk),
        .rst        (in_Rst),
        .boot_data  (in_boot_data),
        .boot_valid (in_boot_valid),
        .boot_ready (out_boot_ready),
        .boot_err   (out_boot_err),
        .core_rst_n (out_core_Rst_N),
        .run        (run),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata)
    );

    // Sub-word byte offsets carry no information for word-wide memories.
    assign unused_addr_bits = ^{in_inst_addr[1:0], in_addr[2:0]};

    assign inst_idx = in_inst_addr[2 +: IM_AW];
    assign inst_oor = |in_inst_addr[63:IM_AW+2];
    assign dm_idx   = in_addr[3 +: DM_AW];
    assign dm_oor   = |in_addr[63:DM_AW+3];

    // Instruction memory is written only by the boot loader.
    always_ff @(posedge in_Clk) begin
        if (im_we) im[im_waddr] <= im_wdata;
    end

    // Core stores land only while running and only inside the data memory.
    always_ff @(posedge in_Clk) begin
        if (run && in_DM_wr_en && !dm_oor) dm[dm_idx] <= in_wr_data;
    end

    // Fetch port: NOP until the program is running or when the address is out of range.
    always_comb begin
        out_inst = RV_NOP;
        if (run && !inst_oor) out_inst = im[inst_idx];
    end

    // Load port: out-of-range reads return zero.
    always_comb begin
        out_DM_data = '0;
        if (!dm_oor) out_DM_data = dm[dm_idx];
    end

    // Sticky fault for any out-of-range fetch or data access while running.
    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            out_fault <= 1'b0;
        end else if (run && (inst_oor || dm_oor)) begin
            out_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_boot_mem_responder.sv
// Directed bench for boot_mem_responder: boot sequences, run-phase memory
// vectors and reset/error corner cases.
module tb_boot_mem_responder;

    localparam int IM_WORDS = 1024;
    localparam int DM_WORDS = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  boot_data;
    logic        boot_valid;
    logic        boot_ready;
    logic        boot_err;
    logic        core_rst_n;
    logic [63:0] inst_addr;
    logic [31:0] inst;
    logic [63:0] addr;
    logic [63:0] wr_data;
    logic        wr_en;
    logic [63:0] dm_data;
    logic        fault;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic [63:0] iaddr;
        logic        chk_dm;
        logic [63:0] exp_dm;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    boot_mem_responder #(
        .IM_WORDS (IM_WORDS),
        .DM_WORDS (DM_WORDS)
    ) dut (
        .in_Clk         (clk),
        .in_Rst         (rst),
        .in_boot_data   (boot_data),
        .in_boot_valid  (boot_valid),
        .out_boot_ready (boot_ready),
        .out_boot_err   (boot_err),
        .out_core_Rst_N (core_rst_n),
        .in_inst_addr   (inst_addr),
        .out_inst       (inst),
        .in_addr        (addr),
        .in_wr_data     (wr_data),
        .in_DM_wr_en    (wr_en),
        .out_DM_data    (dm_data),
        .out_fault      (fault)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one byte and hold it until the handshake edge; returns #1 after that edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        boot_data  = b;
        boot_valid = 1'b1;
        while (!boot_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!boot_ready) begin
            chk("boot_ready_timeout", 64'(boot_ready), 64'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        boot_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] bs[], input int len);
        for (int i = 0; i < len; i++) send_byte(bs[i]);
    endtask

    initial begin
        logic [7:0] bs[];

        vecs[0]  = '{64'h10,   64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, 1'b0, 64'h0,                   32'h0010_0093};
        vecs[1]  = '{64'h10,   64'hDEAD_BEEF_CAFE_F00D, 1'b1, 64'h4, 1'b1, 64'h0123_4567_89AB_CDEF, 32'h0020_0113};
        vecs[2]  = '{64'h10,   64'h0,                   1'b0, 64'h7, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 32'h0020_0113};
        vecs[3]  = '{64'h17,   64'h0,                   1'b0, 64'h3, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 32'h0010_0093};
        vecs[4]  = '{64'h18,   64'h55,                  1'b1, 64'h0, 1'b0, 64'h0,                   32'h0010_0093};
        vecs[5]  = '{64'h18,   64'h0,                   1'b0, 64'h4, 1'b1, 64'h55,                  32'h0020_0113};
        vecs[6]  = '{64'h1F,   64'h0,                   1'b0, 64'h0, 1'b1, 64'h55,                  32'h0010_0093};
        vecs[7]  = '{64'h1FF8, 64'hA5A5,                1'b1, 64'h0, 1'b0, 64'h0,                   32'h0010_0093};
        vecs[8]  = '{64'h1FFF, 64'h0,                   1'b0, 64'h0, 1'b1, 64'hA5A5,                32'h0010_0093};
        vecs[9]  = '{64'h0,    64'h77,                  1'b1, 64'h0, 1'b0, 64'h0,                   32'h0010_0093};
        vecs[10] = '{64'h3,    64'h0,                   1'b0, 64'h0, 1'b1, 64'h77,                  32'h0010_0093};

        rst = 1'b1; boot_data = '0; boot_valid = 1'b0;
        inst_addr = '0; addr = '0; wr_data = '0; wr_en = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(boot_ready), 64'd0);
        chk("rst_err",   64'(boot_err),   64'd0);
        chk("rst_core",  64'(core_rst_n), 64'd0);
        chk("rst_fault", 64'(fault),      64'd0);
        chk("rst_inst_nop", 64'(inst), 64'(NOP));
        rst = 1'b0;

        // Boot N=2
        bs = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        send_bytes(bs, 10);
        chk("boot2_ready_run", 64'(boot_ready), 64'd0);
        chk("boot2_core_lat",  64'(core_rst_n), 64'd0);
        @(posedge clk);
        #1;
        chk("boot2_core_rel",  64'(core_rst_n), 64'd1);
        inst_addr = 64'h0; #1; chk("boot2_im0", 64'(inst), 64'h0010_0093);
        inst_addr = 64'h4; #1; chk("boot2_im1", 64'(inst), 64'h0020_0113);
        inst_addr = 64'h5; #1; chk("boot2_im1_lowbits", 64'(inst), 64'h0020_0113);

        // Run-phase data/fetch vectors
        for (int i = 0; i < 11; i++) begin
            addr = vecs[i].addr; wr_data = vecs[i].wdata;
            wr_en = vecs[i].we; inst_addr = vecs[i].iaddr;
            #1;
            if (vecs[i].chk_dm) chk($sformatf("vec%0d_dm", i), dm_data, vecs[i].exp_dm);
            chk($sformatf("vec%0d_inst", i), 64'(inst), 64'(vecs[i].exp_inst));
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        chk("run_no_fault", 64'(fault), 64'd0);

        // Out-of-range store
        addr = 64'(8 * DM_WORDS); wr_data = 64'hBAD0_BAD0_BAD0_BAD0; wr_en = 1'b1;
        #1;
        chk("oor_load_zero", dm_data, 64'd0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("oor_fault_set", 64'(fault), 64'd1);
        addr = 64'h0; #1;
        chk("oor_store_dropped", dm_data, 64'h77);
        @(posedge clk);
        #1;
        chk("oor_fault_sticky", 64'(fault), 64'd1);
        inst_addr = 64'(4 * IM_WORDS); #1;
        chk("oor_fetch_nop", 64'(inst), 64'(NOP));
        inst_addr = 64'h0;

        // N=0 boot
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("n0_rst_fault", 64'(fault), 64'd0);
        chk("n0_rst_core",  64'(core_rst_n), 64'd0);
        rst = 1'b0;
        bs = '{8'h00, 8'h00};
        send_bytes(bs, 2);
        chk("n0_ready_run", 64'(boot_ready), 64'd0);
        #1;
        chk("n0_old_im0", 64'(inst), 64'h0010_0093);
        @(posedge clk);
        #1;
        chk("n0_core_rel", 64'(core_rst_n), 64'd1);

        // Length too large -> ERR
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bs = '{8'h01, 8'h04};
        send_bytes(bs, 2);
        chk("err_flag",  64'(boot_err),   64'd1);
        chk("err_ready", 64'(boot_ready), 64'd0);
        chk("err_core",  64'(core_rst_n), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_hold_core", 64'(core_rst_n), 64'd0);
        chk("err_hold_flag", 64'(boot_err),   64'd1);
        chk("err_inst_nop",  64'(inst),       64'(NOP));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("err_clr_flag",  64'(boot_err),   64'd0);
        chk("err_clr_ready", 64'(boot_ready), 64'd0);
        rst = 1'b0;

        // Reset in the middle of a load, then re-boot N=1
        bs = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_bytes(bs, 7);
        inst_addr = 64'h0; #1;
        chk("midload_fetch_nop", 64'(inst), 64'(NOP));
        addr = 64'h0; wr_data = 64'h99; wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bs = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_bytes(bs, 6);
        chk("reboot_ready_run", 64'(boot_ready), 64'd0);
        inst_addr = 64'h0; #1;
        chk("reboot_im0", 64'(inst), 64'h0000_0013);
        inst_addr = 64'h4; #1;
        chk("reboot_im1_kept", 64'(inst), 64'h0020_0113);
        addr = 64'h0; #1;
        chk("midload_store_ignored", dm_data, 64'h77);
        @(posedge clk);
        #1;
        chk("reboot_core_rel", 64'(core_rst_n), 64'd1);
        chk("reboot_no_fault", 64'(fault), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
